// File: rtl/cpu_pkg.sv
// Shared encodings for the 4-bit-opcode CPU: opcodes, controller states
// and accumulator source selects. Used by the controller, datapath and
// memory model.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_FETCH_MEM = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXEC_MEM  = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  localparam logic [1:0] ACC_SRC_MEM = 2'b00;
  localparam logic [1:0] ACC_SRC_ALU = 2'b01;
  localparam logic [1:0] ACC_SRC_IMM = 2'b10;

endpackage

// File: rtl/opcode_decoder.sv
// Pure combinational opcode classification shared by the controller's
// DECODE and EXEC_MEM paths.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_illegal,
  output logic [1:0] acc_src,
  output logic       alu_sub
);

  // Classify the opcode; acc_src/alu_sub describe the eventual accumulator write
  always_comb begin
    is_mem     = 1'b0;
    is_store   = 1'b0;
    is_illegal = 1'b0;
    acc_src    = ACC_SRC_MEM;
    alu_sub    = 1'b0;
    case (opcode)
      OP_LDA: begin
        is_mem  = 1'b1;
        acc_src = ACC_SRC_MEM;
      end
      OP_ADD: begin
        is_mem  = 1'b1;
        acc_src = ACC_SRC_ALU;
      end
      OP_SUB: begin
        is_mem  = 1'b1;
        acc_src = ACC_SRC_ALU;
        alu_sub = 1'b1;
      end
      OP_STA: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OP_LDI: acc_src = ACC_SRC_IMM;
      OP_NOP, OP_JMP, OP_JZ, OP_OUT, OP_HLT: ;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_controller.sv
// Multi-cycle fetch/decode/execute controller. Issues one-cycle datapath
// strobes and a req/ack memory handshake; instruction length depends on
// the opcode and on memory wait states.
module instruction_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_controller_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mar_sel,
  output logic       mar_load,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic       out_load,
  output logic [1:0] acc_src,
  output logic       alu_sub,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] step
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] op_q;
  logic [3:0] dec_op;
  logic       dec_is_mem;
  logic       dec_is_store;
  logic       dec_is_illegal;
  logic [1:0] dec_acc_src;
  logic       dec_alu_sub;

  // The live opcode is only meaningful in DECODE; EXEC_MEM works from the latched copy
  assign dec_op = (state == ST_DECODE) ? opcode : op_q;
  assign step   = state;

  opcode_decoder u_dec (
    .opcode     (dec_op),
    .is_mem     (dec_is_mem),
    .is_store   (dec_is_store),
    .is_illegal (dec_is_illegal),
    .acc_src    (dec_acc_src),
    .alu_sub    (dec_alu_sub)
  );

  // State register
  always_ff @(posedge clk or negedge reset_controller_n) begin
    if (!reset_controller_n) state <= ST_FETCH;
    else                     state <= state_nxt;
  end

  // Capture the opcode for use after DECODE
  always_ff @(posedge clk or negedge reset_controller_n) begin
    if (!reset_controller_n)     op_q <= OP_NOP;
    else if (state == ST_DECODE) op_q <= opcode;
  end

  // Next-state and Mealy output decode; reset gates everything low at once
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mar_sel   = 1'b0;
    mar_load  = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_load  = 1'b0;
    out_load  = 1'b0;
    acc_src   = ACC_SRC_MEM;
    alu_sub   = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_FETCH: begin
        if (run) begin
          mar_load  = 1'b1;
          state_nxt = ST_FETCH_MEM;
        end
      end
      ST_FETCH_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        illegal   = dec_is_illegal;
        state_nxt = ST_FETCH;
        if (dec_is_mem) begin
          mar_sel   = 1'b1;
          mar_load  = 1'b1;
          state_nxt = ST_EXEC_MEM;
        end else begin
          case (opcode)
            OP_LDI: begin
              acc_load = 1'b1;
              acc_src  = ACC_SRC_IMM;
            end
            OP_JMP:  pc_load   = 1'b1;
            OP_JZ:   pc_load   = zero_flag;
            OP_OUT:  out_load  = 1'b1;
            OP_HLT:  state_nxt = ST_HALTED;
            default: ;
          endcase
        end
      end
      ST_EXEC_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec_is_store;
        if (mem_ack) begin
          acc_load  = ~dec_is_store;
          acc_src   = dec_is_store ? ACC_SRC_MEM : dec_acc_src;
          alu_sub   = dec_alu_sub;
          state_nxt = ST_FETCH;
        end
      end
      ST_HALTED: halted = 1'b1;
      default:   state_nxt = ST_FETCH;
    endcase
    if (!reset_controller_n) begin
      state_nxt = ST_FETCH;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mar_sel   = 1'b0;
      mar_load  = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      acc_load  = 1'b0;
      out_load  = 1'b0;
      acc_src   = ACC_SRC_MEM;
      alu_sub   = 1'b0;
      halted    = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_controller.sv
module tb_instruction_controller;

  logic       clk = 1'b0;
  logic       reset_controller_n;
  logic       run;
  logic [3:0] opcode;
  logic       zero_flag;
  logic       mem_ack;
  logic       mem_req, mem_we, mar_sel, mar_load, ir_load, pc_inc, pc_load;
  logic       acc_load, out_load, alu_sub, halted, illegal;
  logic [1:0] acc_src;
  logic [2:0] step;

  instruction_controller dut (
    .clk                (clk),
    .reset_controller_n (reset_controller_n),
    .run                (run),
    .opcode             (opcode),
    .zero_flag          (zero_flag),
    .mem_ack            (mem_ack),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mar_sel            (mar_sel),
    .mar_load           (mar_load),
    .ir_load            (ir_load),
    .pc_inc             (pc_inc),
    .pc_load            (pc_load),
    .acc_load           (acc_load),
    .out_load           (out_load),
    .acc_src            (acc_src),
    .alu_sub            (alu_sub),
    .halted             (halted),
    .illegal            (illegal),
    .step               (step)
  );

  always #5 clk = ~clk;

  // Output vector layout: req we marsel marld irld pcinc pcld accld outld src[2] sub halt ill step[3]
  localparam logic [16:0] REQ   = 17'h10000;
  localparam logic [16:0] WE    = 17'h08000;
  localparam logic [16:0] MSEL  = 17'h04000;
  localparam logic [16:0] MLD   = 17'h02000;
  localparam logic [16:0] IRLD  = 17'h01000;
  localparam logic [16:0] PCINC = 17'h00800;
  localparam logic [16:0] PCLD  = 17'h00400;
  localparam logic [16:0] ACCLD = 17'h00200;
  localparam logic [16:0] OUTLD = 17'h00100;
  localparam logic [16:0] S_ALU = 17'h00040;
  localparam logic [16:0] S_IMM = 17'h00080;
  localparam logic [16:0] SUBB  = 17'h00020;
  localparam logic [16:0] HALT  = 17'h00010;
  localparam logic [16:0] ILL   = 17'h00008;
  localparam logic [16:0] ST0   = 17'h0;
  localparam logic [16:0] ST1   = 17'h1;
  localparam logic [16:0] ST2   = 17'h2;
  localparam logic [16:0] ST3   = 17'h3;
  localparam logic [16:0] ST4   = 17'h4;

  typedef struct {
    string       name;
    logic        run;
    logic [3:0]  op;
    logic        zf;
    logic        ack;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [16:0] act;
  assign act = {mem_req, mem_we, mar_sel, mar_load, ir_load, pc_inc, pc_load,
                acc_load, out_load, acc_src, alu_sub, halted, illegal, step};

  task automatic check(input string n, input logic [16:0] a, input logic [16:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask

  task automatic add(input string n, input logic r, input logic [3:0] op,
                     input logic zf, input logic ack, input logic [16:0] e);
    vec_t v;
    v.name = n; v.run = r; v.op = op; v.zf = zf; v.ack = ack; v.exp = e;
    vecs.push_back(v);
  endtask

  // FETCH with run, then a zero-wait instruction fetch
  task automatic add_fetch(input string n);
    add({n, "_fetch"}, 1'b1, 4'h3, 1'b0, 1'b0, MLD | ST0);
    add({n, "_fmem"},  1'b0, 4'h3, 1'b0, 1'b1, REQ | IRLD | PCINC | ST1);
  endtask

  initial begin
    reset_controller_n = 1'b0;
    run       = 1'b1;
    opcode    = 4'b0001;
    zero_flag = 1'b0;
    mem_ack   = 1'b1;

    // Table: first FETCH cycle is checked by hand right after reset release
    add("nop_fmem",   1'b0, 4'h3, 1'b0, 1'b1, REQ | IRLD | PCINC | ST1);
    add("nop_dec",    1'b0, 4'h0, 1'b0, 1'b0, ST2);
    add_fetch("ldi");
    add("ldi_dec",    1'b0, 4'h5, 1'b0, 1'b0, ACCLD | S_IMM | ST2);
    add_fetch("sub");
    add("sub_dec",    1'b0, 4'h3, 1'b0, 1'b0, MSEL | MLD | ST2);
    add("sub_wait1",  1'b0, 4'h0, 1'b0, 1'b0, REQ | ST3);
    add("sub_wait2",  1'b0, 4'h0, 1'b0, 1'b0, REQ | ST3);
    add("sub_wait3",  1'b0, 4'h0, 1'b0, 1'b0, REQ | ST3);
    add("sub_ack",    1'b0, 4'h0, 1'b0, 1'b1, REQ | ACCLD | S_ALU | SUBB | ST3);
    add("idle_ack",   1'b0, 4'h0, 1'b0, 1'b1, ST0);
    add_fetch("lda");
    add("lda_dec",    1'b0, 4'h1, 1'b0, 1'b0, MSEL | MLD | ST2);
    add("lda_ack",    1'b0, 4'h0, 1'b0, 1'b1, REQ | ACCLD | ST3);
    add_fetch("add");
    add("add_dec",    1'b0, 4'h2, 1'b0, 1'b0, MSEL | MLD | ST2);
    add("add_ack",    1'b0, 4'h3, 1'b0, 1'b1, REQ | ACCLD | S_ALU | ST3);
    add("sta_fetch",  1'b1, 4'h0, 1'b0, 1'b0, MLD | ST0);
    add("sta_fwait",  1'b0, 4'h0, 1'b0, 1'b0, REQ | ST1);
    add("sta_fmem",   1'b0, 4'h0, 1'b0, 1'b1, REQ | IRLD | PCINC | ST1);
    add("sta_dec",    1'b0, 4'h4, 1'b0, 1'b0, MSEL | MLD | ST2);
    add("sta_wait",   1'b0, 4'h0, 1'b0, 1'b0, REQ | WE | ST3);
    add("sta_ack",    1'b0, 4'h0, 1'b0, 1'b1, REQ | WE | ST3);
    add_fetch("jz0");
    add("jz0_dec",    1'b0, 4'h7, 1'b0, 1'b0, ST2);
    add_fetch("jz1");
    add("jz1_dec",    1'b0, 4'h7, 1'b1, 1'b0, PCLD | ST2);
    add_fetch("jmp");
    add("jmp_dec",    1'b0, 4'h6, 1'b0, 1'b0, PCLD | ST2);
    add_fetch("out");
    add("out_dec",    1'b0, 4'he, 1'b1, 1'b1, OUTLD | ST2);
    add_fetch("ill");
    add("ill_dec",    1'b0, 4'h8, 1'b0, 1'b0, ILL | ST2);
    add_fetch("hlt");
    add("hlt_dec",    1'b0, 4'hf, 1'b0, 1'b0, ST2);
    for (int k = 0; k < 20; k++)
      add($sformatf("halted_%0d", k), k[0], 4'h1, 1'b0, k[1], HALT | ST4);

    // Reset held with run=1, opcode=LDA, mem_ack high
    repeat (3) begin
      @(negedge clk);
      #1 check("reset_hold", act, ST0);
    end
    @(negedge clk);
    reset_controller_n = 1'b1;
    run     = 1'b1;
    mem_ack = 1'b0;
    #1 check("first_fetch", act, MLD | ST0);

    foreach (vecs[i]) begin
      @(negedge clk);
      run       = vecs[i].run;
      opcode    = vecs[i].op;
      zero_flag = vecs[i].zf;
      mem_ack   = vecs[i].ack;
      #1 check(vecs[i].name, act, vecs[i].exp);
    end

    // Leave HALTED through reset, then reset in the middle of EXEC_MEM
    @(negedge clk);
    reset_controller_n = 1'b0;
    #1 check("halt_reset", act, ST0);
    @(negedge clk);
    reset_controller_n = 1'b1;
    run = 1'b1; mem_ack = 1'b0; opcode = 4'h1;
    #1 check("r2_fetch", act, MLD | ST0);
    @(negedge clk);
    run = 1'b0; mem_ack = 1'b1;
    #1 check("r2_fmem", act, REQ | IRLD | PCINC | ST1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1 check("r2_dec", act, MSEL | MLD | ST2);
    @(negedge clk);
    #1 check("r2_exec_req", act, REQ | ST3);
    #1 reset_controller_n = 1'b0;
    #1 check("r2_async_drop", act, ST0);
    @(negedge clk);
    reset_controller_n = 1'b1;
    #1 check("r2_after_rel", act, ST0);
    @(negedge clk);
    #1 check("r2_idle", act, ST0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
